// File: rtl/expr_recognizer_pkg.sv
// Shared types and constants for the streaming expression recogniser.
// Contents: FSM state enum, ASCII character codes, operator-mask bit positions.
// Imported by char_classifier and expr_recognizer.
package expr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NUM  = 2'd1,
        OPR  = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [7:0] CH_0     = 8'd48;
    localparam logic [7:0] CH_9     = 8'd57;
    localparam logic [7:0] CH_PLUS  = 8'd43;
    localparam logic [7:0] CH_STAR  = 8'd42;
    localparam logic [7:0] CH_MINUS = 8'd45;
    localparam logic [7:0] CH_SLASH = 8'd47;
    localparam logic [7:0] CH_EQ    = 8'd61;

    // Bit positions within the operator enable mask.
    localparam int OPB_PLUS  = 0;
    localparam int OPB_STAR  = 1;
    localparam int OPB_MINUS = 2;
    localparam int OPB_SLASH = 3;

endpackage

// File: rtl/expr_recognizer_char_classifier.sv
// Purely combinational ASCII character classifier (digit / enabled operator / '=').
// Ports: in_char_i, op_mask_i in; is_digit_o, is_op_o, is_term_o, digit_val_o out.
// Operators whose mask bit is clear are reported as neither op nor digit nor term.
module char_classifier
    import expr_pkg::*;
(
    input  logic [7:0] in_char_i,
    input  logic [3:0] op_mask_i,
    output logic       is_digit_o,
    output logic       is_op_o,
    output logic       is_term_o,
    output logic [3:0] digit_val_o
);

    always_comb begin
        is_digit_o  = (in_char_i >= CH_0) && (in_char_i <= CH_9);
        // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
        digit_val_o = is_digit_o ? in_char_i[3:0] : 4'd0;
        is_op_o     = ((in_char_i == CH_PLUS)  && op_mask_i[OPB_PLUS])  ||
                      ((in_char_i == CH_STAR)  && op_mask_i[OPB_STAR])  ||
                      ((in_char_i == CH_MINUS) && op_mask_i[OPB_MINUS]) ||
                      ((in_char_i == CH_SLASH) && op_mask_i[OPB_SLASH]);
        is_term_o   = (in_char_i == CH_EQ);
    end

endmodule

// File: rtl/expr_recognizer.sv
// Streaming recogniser for NUM (OP NUM)* '=' expressions, one character per valid cycle.
// Ports: clk, clr_n, in_valid, in_char in; match, err, done, accept, num_count, op_count,
// operand_val out (all registered). Optional macro EXPR_OPERAND_VAL_EN enables operand_val.
module expr_recognizer
    import expr_pkg::*;
#(
    parameter int         MAX_DIGITS = 4,
    parameter int         CNT_W      = 8,
    parameter logic [3:0] OP_MASK    = 4'b0011,
    parameter int         VAL_W      = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             match,
    output logic             err,
    output logic             done,
    output logic             accept,
    output logic [CNT_W-1:0] num_count,
    output logic [CNT_W-1:0] op_count,
    output logic [VAL_W-1:0] operand_val
);

    localparam int DC_W = $clog2(MAX_DIGITS + 1);
    localparam logic [DC_W-1:0]  DC_MAX  = DC_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic       is_digit, is_op, is_term;
    logic [3:0] digit_val;

    char_classifier u_classifier (
        .in_char_i   (in_char),
        .op_mask_i   (OP_MASK),
        .is_digit_o  (is_digit),
        .is_op_o     (is_op),
        .is_term_o   (is_term),
        .digit_val_o (digit_val)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] op_q, op_d;
    logic [DC_W-1:0]  dc_q, dc_d;
    logic             match_q, err_q, done_q, accept_q;
    logic             done_d, accept_d;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        op_d     = op_q;
        dc_d     = dc_q;
        done_d   = 1'b0;
        accept_d = accept_q;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (is_digit) begin
                        state_d = NUM;
                        num_d   = CNT_W'(1);
                        op_d    = '0;
                        dc_d    = DC_W'(1);
                    end else if (is_term) begin
                        // Empty expression: terminated but rejected.
                        done_d   = 1'b1;
                        accept_d = 1'b0;
                    end else begin
                        state_d = ERR;
                    end
                end
                NUM: begin
                    if (is_digit) begin
                        if (dc_q < DC_MAX) dc_d = dc_q + DC_W'(1);
                        else               state_d = ERR;   // operand too long
                    end else if (is_op) begin
                        state_d = OPR;
                        op_d    = (op_q == CNT_SAT) ? op_q : op_q + CNT_W'(1);
                        dc_d    = '0;
                    end else if (is_term) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        accept_d = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
                OPR: begin
                    if (is_digit) begin
                        state_d = NUM;
                        num_d   = (num_q == CNT_SAT) ? num_q : num_q + CNT_W'(1);
                        dc_d    = DC_W'(1);
                    end else if (is_term) begin
                        // Trailing operator.
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        accept_d = 1'b0;
                    end else begin
                        state_d = ERR;
                    end
                end
                ERR: begin
                    // Counts stay frozen until the expression is terminated.
                    if (is_term) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        accept_d = 1'b0;
                    end
                end
                default: state_d = ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            num_q    <= '0;
            op_q     <= '0;
            dc_q     <= '0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            op_q     <= op_d;
            dc_q     <= dc_d;
            match_q  <= (state_d == NUM);
            err_q    <= (state_d == ERR);
            done_q   <= done_d;
            accept_q <= accept_d;
        end
    end

    assign match     = match_q;
    assign err       = err_q;
    assign done      = done_q;
    assign accept    = accept_q;
    assign num_count = num_q;
    assign op_count  = op_q;

`ifdef EXPR_OPERAND_VAL_EN
    logic [VAL_W-1:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (in_valid && is_digit) begin
            if (state_q == IDLE || state_q == OPR) begin
                val_d = VAL_W'(digit_val);
            end else if (state_q == NUM && dc_q < DC_MAX) begin
                // Accumulate only while the digit keeps us in NUM; wraps modulo 2^VAL_W.
                val_d = VAL_W'(val_q * VAL_W'(10)) + VAL_W'(digit_val);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) val_q <= '0;
        else        val_q <= val_d;
    end

    assign operand_val = val_q;
`else
    // Digit value only feeds the optional accumulator.
    logic unused_digit_val;
    assign unused_digit_val = ^digit_val;
    assign operand_val      = '0;
`endif

endmodule

// File: tb/tb_expr_recognizer.sv
module tb_expr_recognizer;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'd0;

    logic        match, err, done, accept;
    logic [7:0]  num_count, op_count;
    logic [15:0] operand_val;

    logic        match_b, err_b, done_b, accept_b;
    logic [7:0]  num_count_b, op_count_b;
    logic [15:0] operand_val_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    expr_recognizer dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .in_valid    (in_valid),
        .in_char     (in_char),
        .match       (match),
        .err         (err),
        .done        (done),
        .accept      (accept),
        .num_count   (num_count),
        .op_count    (op_count),
        .operand_val (operand_val)
    );

    // Same stream, with '-' enabled.
    expr_recognizer #(.OP_MASK(4'b0111)) dut_sub (
        .clk         (clk),
        .clr_n       (clr_n),
        .in_valid    (in_valid),
        .in_char     (in_char),
        .match       (match_b),
        .err         (err_b),
        .done        (done_b),
        .accept      (accept_b),
        .num_count   (num_count_b),
        .op_count    (op_count_b),
        .operand_val (operand_val_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one character for exactly one rising edge, then sample #1 after it.
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_char  = 8'd0;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_match", match, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_accept", accept, 0);
        check("rst_num", num_count, 0);
        check("rst_op", op_count, 0);
        check("rst_val", operand_val, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // "12+3="
        send("1"); check("a_match1", match, 1);
        send("2"); check("a_match2", match, 1);
        send("+"); check("a_match3", match, 0);
                   check("a_err3", err, 0);
        send("3"); check("a_match4", match, 1);
        send("="); check("a_done", done, 1);
                   check("a_accept", accept, 1);
                   check("a_num", num_count, 2);
                   check("a_op", op_count, 1);
                   check("a_match5", match, 0);
`ifdef EXPR_OPERAND_VAL_EN
                   check("a_val", operand_val, 3);
`else
                   check("a_val", operand_val, 0);
`endif
        @(posedge clk); #1;
        check("a_done_pulse", done, 0);
        check("a_accept_hold", accept, 1);
        check("a_num_hold", num_count, 2);

        // "+5="
        send("+"); check("b_err1", err, 1);
        send("5"); check("b_err2", err, 1);
                   check("b_match2", match, 0);
                   check("b_num_frozen", num_count, 2);
        send("="); check("b_done", done, 1);
                   check("b_accept", accept, 0);
                   check("b_err3", err, 0);

        // "12345=" with MAX_DIGITS=4
        send("1"); send("2"); send("3");
        send("4"); check("c_err4", err, 0);
                   check("c_match4", match, 1);
        send("5"); check("c_err5", err, 1);
        send("="); check("c_done", done, 1);
                   check("c_accept", accept, 0);
                   check("c_num", num_count, 1);

        // "7-2=": '-' disabled on dut, enabled on dut_sub
        send("7");
        send("-"); check("d_err", err, 1);
                   check("d_sub_err", err_b, 0);
        send("2"); check("d_sub_match", match_b, 1);
        send("="); check("d_accept", accept, 0);
                   check("d_sub_done", done_b, 1);
                   check("d_sub_accept", accept_b, 1);
                   check("d_sub_op", op_count_b, 1);
                   check("d_sub_num", num_count_b, 2);

        // "9*" then 10 idle cycles, then "8="
        send("9");
        send("*"); check("e_match_opr", match, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("e_gap_done", done, 0);
            check("e_gap_err", err, 0);
        end
        check("e_gap_op", op_count, 1);
        send("8"); check("e_match", match, 1);
        send("="); check("e_done", done, 1);
                   check("e_accept", accept, 1);
                   check("e_num", num_count, 2);

        // Back-to-back terminator: another pulse, rejected
        send("="); check("f_done", done, 1);
                   check("f_accept", accept, 0);
                   check("f_num_hold", num_count, 2);

        // Asynchronous reset mid "34"
        send("3"); send("4");
        check("g_match_pre", match, 1);
        @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("g_match_rst", match, 0);
        check("g_num_rst", num_count, 0);
        check("g_err_rst", err, 0);
        #1 clr_n = 1'b1;
        send("5");
        send("="); check("g_done", done, 1);
                   check("g_accept", accept, 1);
                   check("g_num", num_count, 1);
                   check("g_op", op_count, 0);

        // Counter saturation: 257 operands, 256 operators
        for (int i = 0; i < 256; i++) begin
            send("1");
            send("+");
        end
        send("1");
        send("="); check("h_accept", accept, 1);
                   check("h_num_sat", num_count, 255);
                   check("h_op_sat", op_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/expr_recognizer.md
Name: expr_recognizer

Overview:
- Streaming recogniser for ASCII arithmetic expressions of the form NUM (OP NUM)* terminated by '='.
- NUM is 1..MAX_DIGITS decimal digits; the operator set is selectable by parameter.
- Consumes one character per valid cycle and reports: live "complete-so-far" match, sticky error, per-expression verdict, operand/operator counts.
- Sits after the character input path, ahead of the calculator datapath.

Parameters:
- MAX_DIGITS, 4, maximum digits per operand (>=1).
- CNT_W, 8, width of operand and operator counters.
- OP_MASK, 4'b0011, enabled operators: bit0 '+'(43), bit1 '*'(42), bit2 '-'(45), bit3 '/'(47).
- VAL_W, 16, width of operand value output (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_char valid this cycle
- in_char  in  8  ASCII character
- match  out  1  expression so far is complete (state NUM)
- err  out  1  expression in error state
- done  out  1  one-cycle pulse: '=' consumed
- accept  out  1  verdict of last terminated expression, held until next done
- num_count  out  CNT_W  operands seen in current/last expression
- op_count  out  CNT_W  operators seen in current/last expression
- operand_val  out  VAL_W  decimal value of current/last operand (see Optional Feature)

Behaviour:
- Reset (clr_n=0, asynchronous): state IDLE; match, err, done, accept = 0; counts = 0; digit_cnt = 0; operand_val = 0.
- All outputs are registered; effects appear the cycle after the character is sampled.
- in_valid=0: state, counts and accept hold; done=0.
- Character classes:
  - DIGIT: 48..57.
  - OP: an enabled operator per OP_MASK.
  - TERM: '=' (61).
  - OTHER: everything else, including disabled operators.
- State transitions (in_valid=1):
  - IDLE:
    - DIGIT -> NUM; num_count=1, op_count=0, digit_cnt=1.
    - TERM -> IDLE; done=1, accept=0 (empty expression rejected).
    - OP or OTHER -> ERR.
  - NUM:
    - DIGIT with digit_cnt<MAX_DIGITS -> NUM; digit_cnt+1.
    - DIGIT with digit_cnt==MAX_DIGITS -> ERR (operand overflow).
    - OP -> OPR; op_count+1, digit_cnt=0.
    - TERM -> IDLE; done=1, accept=1.
    - OTHER -> ERR.
  - OPR:
    - DIGIT -> NUM; num_count+1, digit_cnt=1.
    - TERM -> IDLE; done=1, accept=0 (trailing operator).
    - OP or OTHER -> ERR.
  - ERR:
    - TERM -> IDLE; done=1, accept=0.
    - Anything else: stay in ERR; counts frozen.
- match=1 iff next state is NUM. err=1 iff next state is ERR.
- done is high for exactly one cycle per TERM consumed.
- Counters saturate at 2^CNT_W-1; no wrap.
- After TERM, counts hold the finished expression's values until the first DIGIT of the next expression clears or reloads them.
- Back-to-back TERMs produce one done pulse each; every one after the first has accept=0.

Optional Feature:
- Macro: EXPR_OPERAND_VAL_EN.
- Defined:
  - On a DIGIT that enters NUM: operand_val = digit.
  - On each further DIGIT in NUM: operand_val = operand_val*10 + digit, modulo 2^VAL_W.
  - Holds through OP, TERM and ERR.
  - Reset to 0.
- Undefined: operand_val tied to 0; no multiplier/adder logic is synthesised.

Decomposition:
- Package expr_pkg:
  - state enum {IDLE, NUM, OPR, ERR}.
  - ASCII constants: CH_0, CH_9, CH_PLUS, CH_STAR, CH_MINUS, CH_SLASH, CH_EQ.
  - OP_MASK bit-position constants.
- Sub-module char_classifier: purely combinational.
  - Inputs: in_char, OP_MASK.
  - Outputs: is_digit, is_op, is_term, digit_val[3:0].
- The FSM, counters and value accumulator stay in expr_recognizer.

Test Plan:
- "12+3=" with defaults:
  - match = 1,1,0,1 after each of the first four chars.
  - done pulse with accept=1, num_count=2, op_count=1.
  - With EXPR_OPERAND_VAL_EN: operand_val=3.
- "+5=": err=1 after '+' and stays 1 after '5'; on '=', done=1, accept=0, err clears.
- "12345=" with MAX_DIGITS=4: err rises on the 5th digit; '=' gives accept=0.
- "7-2=": with OP_MASK=4'b0011, '-' gives err and accept=0; with OP_MASK=4'b0111, accept=1, op_count=1.
- "9*" then in_valid held low 10 cycles, then "8=": state holds OPR during the gap, no done; final accept=1, num_count=2.
- clr_n pulsed low mid-"34+": outputs zero asynchronously; next "5=" gives accept=1, num_count=1, op_count=0.
